// File: rtl/reindeer_instruction_queue.sv
// Fetch-to-decode decoupling FIFO: captures fetched {IR, PC}, hands the head to
// decode over valid/ready, and issues credit-limited fetch_next requests.
module reindeer_instruction_queue #(
  parameter int DEPTH           = 4,
  parameter int PTR_BITS        = 2,
  parameter int MAX_OUTSTANDING = 1,
  parameter int XLEN            = 32,
  parameter int PC_BITWIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   flush,
  input  logic                   halt_req,
  output logic                   halt_ack,
  input  logic                   fetch_enable_in,
  input  logic [XLEN-1:0]        IR_in,
  input  logic [PC_BITWIDTH-1:0] PC_in,
  output logic                   fetch_next_out,
  output logic                   valid_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  input  logic                   deq_ready,
  output logic [PTR_BITS:0]      count_out,
  output logic                   overflow_err
);

  localparam int CNT_W = PTR_BITS + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALTING = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]             state_q,  state_d;
  logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q,  count_d;
  logic [CNT_W-1:0]       outst_q,  outst_d;
  logic                   ovf_q,    ovf_d;
  logic [XLEN-1:0]        ir_mem_q [DEPTH];
  logic [PC_BITWIDTH-1:0] pc_mem_q [DEPTH];

  logic                   deq_s;
  logic                   resp_s;
  logic                   full_s;
  logic                   enq_s;
  logic [CNT_W:0]         credit_s;
  logic                   fetch_next_s;

  // Handshake qualification and credit check; credit counts a same-cycle dequeue as freed.
  always_comb begin
    deq_s        = (count_q != '0) && deq_ready;
    resp_s       = fetch_enable_in && (state_q != ST_IDLE) && !flush;
    full_s       = (count_q == DEPTH_C);
    enq_s        = resp_s && (!full_s || deq_s);
    credit_s     = {1'b0, count_q - CNT_W'(deq_s)} + {1'b0, outst_q};
    fetch_next_s = (state_q == ST_RUN) && !flush && !sync_reset && !halt_req &&
                   (outst_q < MAX_OUT_C) && (credit_s < {1'b0, DEPTH_C});
  end

  // Next-state for pointers, occupancy, outstanding credits, error flag and FSM.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    ovf_d    = ovf_q;
    if (flush) begin
      // The fetch stage issues the redirect read itself, so one read is already in flight.
      state_d  = ST_RUN;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      outst_d  = CNT_W'(1);
    end else begin
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
      if (resp_s && full_s && !deq_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      case ({fetch_next_s, resp_s && (outst_q != '0)})
        2'b10:   outst_d = outst_q + CNT_W'(1);
        2'b01:   outst_d = outst_q - CNT_W'(1);
        default: outst_d = outst_q;
      endcase
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_HALTING;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALTING: begin
          if (!halt_req) begin
            state_d = ST_RUN;
          end else if (outst_q == '0) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_HALTING;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers with async and synchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (sync_reset) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (enq_s && !sync_reset) begin
      ir_mem_q[wr_ptr_q] <= IR_in;
      pc_mem_q[wr_ptr_q] <= PC_in;
    end
  end

  // Head presentation and status, all derived from registered state.
  always_comb begin
    valid_out      = (count_q != '0);
    count_out      = count_q;
    overflow_err   = ovf_q;
    halt_ack       = (state_q == ST_HALTED) && (outst_q == '0);
    fetch_next_out = fetch_next_s;
    if (count_q != '0) begin
      IR_out = ir_mem_q[rd_ptr_q];
      PC_out = pc_mem_q[rd_ptr_q];
    end else begin
      IR_out = '0;
      PC_out = '0;
    end
  end

endmodule

// File: tb/tb_reindeer_instruction_queue.sv
// Scoreboard bench for reindeer_instruction_queue: a fetch-stage model pushes the
// expected {IR, PC} when it answers, a monitor pops and compares on every dequeue.
module tb_reindeer_instruction_queue;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset, flush, halt_req, halt_ack;
  logic        fetch_enable_in, fetch_next_out, valid_out, deq_ready, overflow_err;
  logic [31:0] IR_in, PC_in, IR_out, PC_out;
  logic [2:0]  count_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  int          lat, pend_cnt;
  bit          pend, inj_on, inj_exp, found;
  logic [31:0] flush_pc, next_pc, pend_pc, inj_pc;

  always #5 clk = ~clk;

  reindeer_instruction_queue dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .flush(flush),
    .halt_req(halt_req), .halt_ack(halt_ack), .fetch_enable_in(fetch_enable_in),
    .IR_in(IR_in), .PC_in(PC_in), .fetch_next_out(fetch_next_out),
    .valid_out(valid_out), .IR_out(IR_out), .PC_out(PC_out),
    .deq_ready(deq_ready), .count_out(count_out), .overflow_err(overflow_err)
  );

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'h0000_0013 ^ {4'h0, pc[7:0], 20'h0_0000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Fetch-stage model: latches requests at the negedge, answers lat cycles later.
  task automatic fetch_model();
    forever begin
      @(negedge clk);
      if (!reset_n || sync_reset) begin
        pend = 1'b0;
      end else if (flush) begin
        pend = 1'b1; pend_cnt = lat; pend_pc = flush_pc; next_pc = flush_pc + 32'd4;
      end else if (fetch_next_out) begin
        pend = 1'b1; pend_cnt = lat; pend_pc = next_pc; next_pc = next_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      fetch_enable_in = 1'b0;
      if (inj_on) begin
        fetch_enable_in = 1'b1; PC_in = inj_pc; IR_in = ir_of(inj_pc);
        if (inj_exp) sb.push_back({ir_of(inj_pc), inj_pc});
      end else if (pend) begin
        if (pend_cnt <= 1) begin
          fetch_enable_in = 1'b1; PC_in = pend_pc; IR_in = ir_of(pend_pc);
          sb.push_back({ir_of(pend_pc), pend_pc});
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [63:0] exp_v;
    forever begin
      @(negedge clk);
      if (!reset_n || sync_reset || flush) begin
        sb.delete();
      end else if (valid_out && deq_ready) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          chk("sb_head", {IR_out, PC_out}, exp_v);
        end
      end
    end
  endtask

  task automatic inject(input logic [31:0] pc, input bit exp_acc);
    inj_pc = pc; inj_exp = exp_acc; inj_on = 1'b1;
    step();
    inj_on = 1'b0;
    step();
  endtask

  task automatic wait_count(input logic [2:0] target, input int budget, input string name);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (count_out == target) found = 1'b1;
    end
    chk(name, 64'(found), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (valid_out) found = 1'b1;
    end
    chk(name, 64'(found), 64'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {valid_out, fetch_next_out, halt_ack, overflow_err, count_out, 32'd0},
        64'd0);
    chk(name, {IR_out, PC_out}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; flush = 1'b0; halt_req = 1'b0; deq_ready = 1'b0;
    fetch_enable_in = 1'b0; IR_in = 32'd0; PC_in = 32'd0;
    lat = 2; pend = 1'b0; pend_cnt = 0; pend_pc = 32'd0; next_pc = 32'd0; flush_pc = 32'd0;
    inj_on = 1'b0; inj_exp = 1'b0; inj_pc = 32'd0; found = 1'b0;
    fork
      fetch_model();
      monitor();
    join_none

    // Reset state and IDLE ignoring responses
    repeat (2) step();
    chk_all_zero("reset_outputs");
    reset_n = 1'b1;
    step();
    inject(32'h0000_0080, 1'b0);
    chk("idle_ignore_count", 64'(count_out), 64'd0);
    chk("idle_fetch_next", 64'(fetch_next_out), 64'd0);

    // Flush to 0x100, 2-cycle fetch latency, no dequeue: fill to 4
    flush_pc = 32'h100; lat = 2; flush = 1'b1;
    step(); flush = 1'b0;
    chk("t1_valid_e1", 64'(valid_out), 64'd0);
    chk("t1_fn_e1", 64'(fetch_next_out), 64'd0);
    step();
    chk("t1_valid_e2", 64'(valid_out), 64'd0);
    step();
    chk("t1_valid_e3", 64'(valid_out), 64'd1);
    chk("t1_pc_head", 64'(PC_out), 64'h100);
    chk("t1_ir_head", 64'(IR_out), 64'h13);
    chk("t1_fn_next", 64'(fetch_next_out), 64'd1);
    wait_count(3'd4, 40, "t1_fill_timeout");
    repeat (4) step();
    chk("t1_count_full", 64'(count_out), 64'd4);
    chk("t1_fn_full", 64'(fetch_next_out), 64'd0);
    chk("t1_ovf", 64'(overflow_err), 64'd0);
    chk("t1_pc_head_full", 64'(PC_out), 64'h100);

    // Streaming with 1-cycle latency and continuous dequeue
    lat = 1; deq_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("t2_count_le4", 64'(count_out <= 3'd4), 64'd1);
    end
    deq_ready = 1'b0;
    wait_count(3'd4, 40, "t2_refill_timeout");
    repeat (3) step();

    // Forced response into a full queue without dequeue
    chk("t4_head_before", 64'(PC_out), 64'(sb[0][31:0]));
    inject(32'h0000_0F00, 1'b0);
    chk("t4_ovf_set", 64'(overflow_err), 64'd1);
    chk("t4_count_kept", 64'(count_out), 64'd4);
    chk("t4_head_kept", 64'(PC_out), 64'(sb[0][31:0]));
    repeat (3) step();
    chk("t4_ovf_sticky", 64'(overflow_err), 64'd1);

    // Synchronous reset clears everything including the sticky error
    sync_reset = 1'b1;
    step(); sync_reset = 1'b0;
    chk("srst_count", 64'(count_out), 64'd0);
    chk("srst_ovf", 64'(overflow_err), 64'd0);
    chk("srst_valid", 64'(valid_out), 64'd0);
    step();
    chk("srst_idle_fn", 64'(fetch_next_out), 64'd0);

    // Refill from 0x400, then forced response with same-cycle dequeue is accepted
    flush_pc = 32'h400; lat = 1; flush = 1'b1;
    step(); flush = 1'b0;
    wait_count(3'd4, 40, "t4b_fill_timeout");
    repeat (3) step();
    inj_pc = 32'h0000_0F04; inj_exp = 1'b1; inj_on = 1'b1;
    step(); inj_on = 1'b0; deq_ready = 1'b1;
    step();
    step(); deq_ready = 1'b0;
    chk("t4b_no_ovf", 64'(overflow_err), 64'd0);
    chk("t4b_count", 64'(count_out), 64'd4);

    // Flush with 3 queued and a response landing in the flush cycle
    lat = 2; deq_ready = 1'b1;
    step(); deq_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fetch_enable_in && count_out == 3'd3) found = 1'b1;
      else step();
    end
    chk("t3_setup_timeout", 64'(found), 64'd1);
    flush_pc = 32'h200; flush = 1'b1;
    step(); flush = 1'b0;
    chk("t3_valid_after_flush", 64'(valid_out), 64'd0);
    chk("t3_count_after_flush", 64'(count_out), 64'd0);
    wait_valid(10, "t3_resp_timeout");
    chk("t3_pc_head", 64'(PC_out), 64'h200);
    chk("t3_count", 64'(count_out), 64'd1);

    // Halt with a read in flight
    chk("t5_fn_before", 64'(fetch_next_out), 64'd1);
    halt_req = 1'b1; #1;
    chk("t5_fn_comb_drop", 64'(fetch_next_out), 64'd0);
    halt_req = 1'b0; #1;
    chk("t5_fn_comb_back", 64'(fetch_next_out), 64'd1);
    step();
    halt_req = 1'b1;
    chk("t5_fn_halting", 64'(fetch_next_out), 64'd0);
    chk("t5_ack_early", 64'(halt_ack), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (halt_ack) found = 1'b1;
    end
    chk("t5_ack_timeout", 64'(found), 64'd1);
    chk("t5_count_drained", 64'(count_out), 64'd2);
    repeat (2) step();
    chk("t5_ack_hold", 64'(halt_ack), 64'd1);
    chk("t5_fn_halted", 64'(fetch_next_out), 64'd0);
    deq_ready = 1'b1;
    step(); deq_ready = 1'b0;
    chk("t5_deq_halted", 64'(count_out), 64'd1);
    chk("t5_head_halted", 64'(PC_out), 64'h204);
    halt_req = 1'b0; #1;
    chk("t5_fn_still_halted", 64'(fetch_next_out), 64'd0);
    step();
    chk("t5_ack_release", 64'(halt_ack), 64'd0);
    chk("t5_fn_resume", 64'(fetch_next_out), 64'd1);

    // Stream out, then async reset with 2 entries queued
    deq_ready = 1'b1;
    repeat (20) step();
    deq_ready = 1'b0;
    wait_count(3'd2, 20, "t6_setup_timeout");
    reset_n = 1'b0; #1;
    chk_all_zero("t6_async_reset");
    step(); reset_n = 1'b1;
    step();
    chk("t6_idle_fn", 64'(fetch_next_out), 64'd0);
    inject(32'h0000_0500, 1'b0);
    chk("t6_idle_ignore", 64'(count_out), 64'd0);
    chk("t6_idle_valid", 64'(valid_out), 64'd0);
    flush_pc = 32'h300; flush = 1'b1;
    step(); flush = 1'b0;
    wait_valid(10, "t6_resp_timeout");
    chk("t6_pc_head", 64'(PC_out), 64'h300);
    deq_ready = 1'b1;
    repeat (8) step();
    deq_ready = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reindeer_instruction_queue.md
Name: reindeer_instruction_queue

Overview:
- Decoupling buffer directly downstream of the instruction fetch stage. It captures each fetched word and PC (fetch_enable/IR/PC) into a small FIFO and presents the head entry to decode with a valid/ready handshake.
- It generates the fetch stage's fetch_next request under credit control, so the queue can never overflow.
- It supports flush on redirect (issued with the fetch stage's fetch_init) and a halt/drain handshake for debug and the scheduler.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- PTR_BITS, 2, log2(DEPTH).
- MAX_OUTSTANDING, 1, maximum fetch requests in flight (fetch stage supports 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset, same effect as reset_n
- flush  in  1  redirect; asserted in the same cycle the scheduler pulses fetch_init
- halt_req  in  1  level; stop requesting fetches and drain in-flight reads
- halt_ack  out  1  in HALTED state with zero outstanding
- fetch_enable_in  in  1  fetch stage output valid pulse
- IR_in  in  `XLEN  fetched instruction
- PC_in  in  `PC_BITWIDTH  PC of IR_in
- fetch_next_out  out  1  request next sequential fetch (to fetch stage fetch_next)
- valid_out  out  1  head entry valid
- IR_out  out  `XLEN  head instruction
- PC_out  out  `PC_BITWIDTH  head PC
- deq_ready  in  1  decode accepts head this cycle
- count_out  out  PTR_BITS+1  occupied entries
- overflow_err  out  1  sticky; enqueue attempted while full without same-cycle dequeue

Behaviour:
- Reset (reset_n low or sync_reset high):
  - state IDLE; rd/wr pointers, count and outstanding all 0.
  - All outputs 0; IR_out and PC_out read as 0 while empty; overflow_err cleared.
- Storage: DEPTH-entry register array {IR, PC}; wr_ptr and rd_ptr wrap modulo DEPTH.
- Head outputs:
  - valid_out = (count != 0); IR_out/PC_out = entry[rd_ptr], from registers with no combinational path from inputs.
  - Latency: entry enqueued at edge N is visible at head after edge N, so valid_out is high in cycle N+1 when the queue was empty.
- Dequeue: valid_out & deq_ready advances rd_ptr. deq_ready while empty is ignored.
- Enqueue: fetch_enable_in writes entry[wr_ptr] and advances wr_ptr.
  - Full with same-cycle dequeue: enqueue is accepted and count is unchanged.
  - Full with no dequeue: data is dropped and overflow_err is set, sticky until reset.
- Outstanding counter (width PTR_BITS+1):
  - +1 when fetch_next_out is high; -1 on an accepted fetch_enable_in; simultaneous +1/-1 leaves it unchanged.
  - Never decrements below 0. A response arriving with outstanding==0 is still enqueued.
- fetch_next_out is combinational and requires all of: state RUN, !flush, !sync_reset, !halt_req, outstanding < MAX_OUTSTANDING, count + outstanding < DEPTH, where count already reflects a same-cycle dequeue.
- Flush:
  - Empties the queue (pointers and count = 0) and sets outstanding = 1, because the fetch_init read is issued by the fetch stage itself.
  - fetch_enable_in in the flush cycle is discarded.
  - Flush has priority over enqueue, dequeue and halt transitions in that cycle.
- FSM states:
  - IDLE: flush -> RUN; otherwise stay. fetch_enable_in is ignored.
  - RUN: halt_req & !flush -> HALTING; flush -> RUN (flushed).
  - HALTING: no new fetch requests; in-flight responses are still enqueued. Outstanding==0 -> HALTED. flush -> RUN (flushed, halt_req ignored that cycle). !halt_req -> RUN.
  - HALTED: halt_ack=1; the queue stays dequeueable. !halt_req -> RUN. flush -> RUN (flushed).
- count_out equals the number of valid entries at all times, in the range 0..DEPTH.

Test Plan:
- Reset then flush with PC 0x100; fetch stage model returns IR 0x00000013 after 2 cycles, deq_ready=0 -> valid_out rises the cycle after the response, PC_out=0x100, fetch_next_out asserts next, fill stops at count_out=4 and outstanding=0, overflow_err=0.
- Full queue with deq_ready=1 continuous and 1-cycle fetch latency -> PCs 0x100,0x104,0x108,… dequeue strictly in order with no duplicates or gaps; count_out stays at or below 4.
- Flush with 3 entries queued and a response arriving in the same cycle -> next cycle valid_out=0 and count_out=0; only the post-flush response (PC 0x200) appears at the head.
- Full queue plus fetch_enable_in forced without dequeue -> overflow_err=1 (sticky), count_out stays 4, head unchanged; same stimulus with deq_ready=1 -> accepted, no error.
- halt_req during an in-flight read -> fetch_next_out drops immediately, the response is enqueued, halt_ack asserts once outstanding reaches 0; dropping halt_req -> RUN and fetch_next_out resumes.
- reset_n pulsed low mid-stream with 2 entries queued -> all outputs 0 asynchronously, state IDLE; fetch_enable_in ignored until the next flush.
